// File: rtl/delay_config_controller.sv
// Serial delay-tap configuration controller: receives framed words over an
// asynchronous serial link, validates them, and applies each on a frame boundary.
module delay_config_controller #(
   parameter int NUM_CHANNELS  = 3,
   parameter int DELAY_WIDTH   = 4,
   parameter int BUFFER_SIZE   = 8,
   parameter int DEFAULT_DELAY = 0
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                cfg_clk,
   input  logic                                cfg_data,
   input  logic                                cfg_en,
   input  logic                                frame_start,
   input  logic                                err_clr,
   output logic [NUM_CHANNELS*DELAY_WIDTH-1:0] delay_out,
   output logic                                busy,
   output logic                                update_ack,
   output logic [2:0]                          cfg_err
);

   localparam int WORD_BITS = 2 + DELAY_WIDTH;
   localparam int CNT_W     = $clog2(WORD_BITS + 2);
   localparam logic [CNT_W-1:0]       CNT_SAT  = CNT_W'(WORD_BITS + 1);
   localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(WORD_BITS);
   localparam logic [DELAY_WIDTH-1:0] VAL_MAX  = DELAY_WIDTH'(BUFFER_SIZE - 1);
   localparam logic [2:0]             CH_LIMIT = 3'(NUM_CHANNELS);
   localparam logic [DELAY_WIDTH-1:0] TAP_RST  = DELAY_WIDTH'(DEFAULT_DELAY);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SHIFT   = 2'd1,
      S_CHECK   = 2'd2,
      S_PENDING = 2'd3
   } state_t;

   logic                                r_clk_meta, r_clk_sync, r_clk_prev;
   logic                                r_data_meta, r_data_sync;
   logic                                r_en_meta, r_en_sync, r_en_prev;
   logic [1:0]                          r_sync_cnt;
   logic                                r_en_armed;
   state_t                              r_state;
   logic [CNT_W-1:0]                    r_cnt;
   logic [WORD_BITS-1:0]                r_shift;
   logic [1:0]                          r_pend_ch;
   logic [DELAY_WIDTH-1:0]              r_pend_val;
   logic [NUM_CHANNELS*DELAY_WIDTH-1:0] r_taps;
   logic                                r_busy, r_ack;
   logic [2:0]                          r_err;

   logic                   w_clk_rise, w_en_rise, w_en_fall;
   logic [1:0]             w_word_ch;
   logic [DELAY_WIDTH-1:0] w_word_val;
   logic                   w_len_bad, w_rng_bad;
   logic [2:0]             w_err_set;

   // A level of cfg_en present at reset release must first be seen low before
   // it may start a word, so edges only count once the synchronizer is armed.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_meta  <= 1'b0;
         r_clk_sync  <= 1'b0;
         r_clk_prev  <= 1'b0;
         r_data_meta <= 1'b0;
         r_data_sync <= 1'b0;
         r_en_meta   <= 1'b0;
         r_en_sync   <= 1'b0;
         r_en_prev   <= 1'b0;
         r_sync_cnt  <= 2'd0;
         r_en_armed  <= 1'b0;
      end else begin
         r_clk_meta  <= cfg_clk;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= cfg_data;
         r_data_sync <= r_data_meta;
         r_en_meta   <= cfg_en;
         r_en_sync   <= r_en_meta;
         r_en_prev   <= r_en_sync;
         r_sync_cnt  <= (r_sync_cnt == 2'd2) ? r_sync_cnt : r_sync_cnt + 2'd1;
         r_en_armed  <= r_en_armed | ((r_sync_cnt == 2'd2) & ~r_en_sync);
      end
   end

   assign w_clk_rise = r_clk_sync & ~r_clk_prev;
   assign w_en_rise  = r_en_sync & ~r_en_prev & r_en_armed;
   assign w_en_fall  = ~r_en_sync & r_en_prev;
   assign w_word_ch  = r_shift[WORD_BITS-1 -: 2];
   assign w_word_val = r_shift[DELAY_WIDTH-1:0];
   assign w_len_bad  = (r_cnt != CNT_FULL);
   assign w_rng_bad  = ({1'b0, w_word_ch} >= CH_LIMIT) || (w_word_val > VAL_MAX);

   // Error events raised this cycle; length is reported in preference to range.
   always_comb begin
      w_err_set = 3'b000;
      case (r_state)
         S_CHECK: begin
            if (w_len_bad) begin
               w_err_set[0] = 1'b1;
            end else if (w_rng_bad) begin
               w_err_set[1] = 1'b1;
            end else begin
               w_err_set = 3'b000;
            end
         end
         S_PENDING: begin
            if (w_en_rise) begin
               w_err_set[2] = 1'b1;
            end else begin
               w_err_set = 3'b000;
            end
         end
         default: w_err_set = 3'b000;
      endcase
   end

   // Word reception, validation and frame-aligned tap update.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_pend_ch  <= 2'b00;
         r_pend_val <= '0;
         r_taps     <= {NUM_CHANNELS{TAP_RST}};
         r_busy     <= 1'b0;
         r_ack      <= 1'b0;
         r_err      <= 3'b000;
      end else begin
         r_ack <= 1'b0;
         r_err <= (err_clr ? 3'b000 : r_err) | w_err_set;
         case (r_state)
            S_IDLE: begin
               if (w_en_rise) begin
                  r_cnt   <= '0;
                  r_shift <= '0;
                  r_state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (w_clk_rise && r_en_sync) begin
                  r_shift <= {r_shift[WORD_BITS-2:0], r_data_sync};
                  if (r_cnt != CNT_SAT) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               if (w_en_fall) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (w_len_bad || w_rng_bad) begin
                  r_state <= S_IDLE;
               end else begin
                  r_pend_ch  <= w_word_ch;
                  r_pend_val <= w_word_val;
                  r_busy     <= 1'b1;
                  r_state    <= S_PENDING;
               end
            end
            S_PENDING: begin
               // A word started here is discarded; only frame_start leaves.
               if (frame_start) begin
                  for (int n = 0; n < NUM_CHANNELS; n++) begin
                     if (r_pend_ch == 2'(n)) begin
                        r_taps[n*DELAY_WIDTH +: DELAY_WIDTH] <= r_pend_val;
                     end
                  end
                  r_ack   <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign delay_out  = r_taps;
   assign busy       = r_busy;
   assign update_ack = r_ack;
   assign cfg_err    = r_err;

endmodule
